// File: rtl/sc_statemachinemove.sv
// Frogger move controller: turns synchronised active-low buttons into one-cycle
// frog-position commands, with edge blocking, hold-to-repeat, lives and WIN/LOSE.
//
// state   | meaning
// RESET   | leaving reset, go to IDLE
// IDLE    | wait for start
// INIT    | clear frog, load lives
// CHECK   | arbitrate collision/goal/start/directions
// MOVE    | one-cycle move command for latched direction
// HOLD    | button held, repeat timer running
// RELEASE | wait until every button is released
// HIT     | frog hit: clear frog, lose a life
// WIN     | frog reached goal row
// LOSE    | no lives left
module sc_statemachinemove #(
  parameter int LIVES_WIDTH   = 2,
  parameter int LIVES_INIT    = 3,
  parameter int TIMER_WIDTH   = 25,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                   SC_STATEMACHINEMOVE_CLOCK_50,
  input  logic                   SC_STATEMACHINEMOVE_RESET_InLow,
  input  logic                   SC_STATEMACHINEMOVE_startButton_InLow,
  input  logic                   SC_STATEMACHINEMOVE_upButton_InLow,
  input  logic                   SC_STATEMACHINEMOVE_downButton_InLow,
  input  logic                   SC_STATEMACHINEMOVE_leftButton_InLow,
  input  logic                   SC_STATEMACHINEMOVE_rightButton_InLow,
  input  logic                   SC_STATEMACHINEMOVE_topsidecomparator_InLow,
  input  logic                   SC_STATEMACHINEMOVE_bottomsidecomparator_InLow,
  input  logic                   SC_STATEMACHINEMOVE_leftsidecomparator_InLow,
  input  logic                   SC_STATEMACHINEMOVE_rightsidecomparator_InLow,
  input  logic                   SC_STATEMACHINEMOVE_collision_InLow,
  input  logic                   SC_STATEMACHINEMOVE_goal_InLow,
  output logic                   SC_STATEMACHINEMOVE_clear_OutLow,
  output logic                   SC_STATEMACHINEMOVE_load0_OutLow,
  output logic                   SC_STATEMACHINEMOVE_load1_OutLow,
  output logic [1:0]             SC_STATEMACHINEMOVE_shiftselection_Out,
  output logic [LIVES_WIDTH-1:0] SC_STATEMACHINEMOVE_lives_Out,
  output logic                   SC_STATEMACHINEMOVE_win_Out,
  output logic                   SC_STATEMACHINEMOVE_gameover_Out,
  output logic [3:0]             SC_STATEMACHINEMOVE_state_Out
);

  typedef enum logic [3:0] {
    stReset   = 4'd0,
    stIdle    = 4'd1,
    stInit    = 4'd2,
    stCheck   = 4'd3,
    stMove    = 4'd4,
    stHold    = 4'd5,
    stRelease = 4'd6,
    stHit     = 4'd7,
    stWin     = 4'd8,
    stLose    = 4'd9
  } stateType;

  localparam logic [TIMER_WIDTH-1:0] delayLast  = TIMER_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [TIMER_WIDTH-1:0] periodLast = TIMER_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [3:0]             cmdIdle    = 4'b1111;

  stateType               state;
  logic [1:0]             dirReg;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   repeatFlag;
  logic [LIVES_WIDTH-1:0] lives;
  logic                   clearReg;
  logic [3:0]             cmdReg;
  logic                   winReg;
  logic                   gameoverReg;

  logic                   allReleased;
  logic                   upValid, downValid, leftValid, rightValid;
  logic                   pickValid;
  logic [1:0]             pickDir;
  logic                   latchedValid;
  logic [TIMER_WIDTH-1:0] timerLast;

  // Command bits are {load0, load1, shift[1:0]}, all active low / 11 = hold.
  function automatic logic [3:0] cmdFor(input logic [1:0] dir);
    case (dir)
      2'd0:    return 4'b0111;
      2'd1:    return 4'b1011;
      2'd2:    return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  assign allReleased = SC_STATEMACHINEMOVE_startButton_InLow & SC_STATEMACHINEMOVE_upButton_InLow &
                       SC_STATEMACHINEMOVE_downButton_InLow & SC_STATEMACHINEMOVE_leftButton_InLow &
                       SC_STATEMACHINEMOVE_rightButton_InLow;

  // A direction pressed toward an edge the frog already touches counts as not pressed.
  assign upValid    = ~SC_STATEMACHINEMOVE_upButton_InLow    & SC_STATEMACHINEMOVE_topsidecomparator_InLow;
  assign downValid  = ~SC_STATEMACHINEMOVE_downButton_InLow  & SC_STATEMACHINEMOVE_bottomsidecomparator_InLow;
  assign leftValid  = ~SC_STATEMACHINEMOVE_leftButton_InLow  & SC_STATEMACHINEMOVE_leftsidecomparator_InLow;
  assign rightValid = ~SC_STATEMACHINEMOVE_rightButton_InLow & SC_STATEMACHINEMOVE_rightsidecomparator_InLow;

  always_comb begin
    pickValid = 1'b1;
    pickDir   = 2'd0;
    if (upValid)         pickDir = 2'd0;
    else if (downValid)  pickDir = 2'd1;
    else if (leftValid)  pickDir = 2'd2;
    else if (rightValid) pickDir = 2'd3;
    else                 pickValid = 1'b0;
  end

  always_comb begin
    case (dirReg)
      2'd0:    latchedValid = upValid;
      2'd1:    latchedValid = downValid;
      2'd2:    latchedValid = leftValid;
      default: latchedValid = rightValid;
    endcase
  end

  assign timerLast = repeatFlag ? periodLast : delayLast;

  always_ff @(posedge SC_STATEMACHINEMOVE_CLOCK_50 or negedge SC_STATEMACHINEMOVE_RESET_InLow) begin
    if (!SC_STATEMACHINEMOVE_RESET_InLow) begin
      state       <= stReset;
      dirReg      <= 2'd0;
      timer       <= '0;
      repeatFlag  <= 1'b0;
      lives       <= '0;
      clearReg    <= 1'b1;
      cmdReg      <= cmdIdle;
      winReg      <= 1'b0;
      gameoverReg <= 1'b0;
    end else begin
      // Outputs are registered against the next state, so each branch sets only what it asserts.
      clearReg    <= 1'b1;
      cmdReg      <= cmdIdle;
      winReg      <= 1'b0;
      gameoverReg <= 1'b0;
      case (state)
        stReset: state <= stIdle;
        stIdle: begin
          if (!SC_STATEMACHINEMOVE_startButton_InLow) begin
            state    <= stInit;
            clearReg <= 1'b0;
          end
        end
        stInit: begin
          state <= stRelease;
          lives <= LIVES_WIDTH'(LIVES_INIT);
        end
        stRelease: begin
          if (allReleased) state <= stCheck;
        end
        stCheck: begin
          if (!SC_STATEMACHINEMOVE_collision_InLow) begin
            state    <= stHit;
            clearReg <= 1'b0;
          end else if (!SC_STATEMACHINEMOVE_goal_InLow) begin
            state  <= stWin;
            winReg <= 1'b1;
          end else if (!SC_STATEMACHINEMOVE_startButton_InLow) begin
            state    <= stInit;
            clearReg <= 1'b0;
          end else if (pickValid) begin
            state      <= stMove;
            dirReg     <= pickDir;
            repeatFlag <= 1'b0;
            cmdReg     <= cmdFor(pickDir);
          end
        end
        stMove: begin
          if (!SC_STATEMACHINEMOVE_collision_InLow) begin
            state    <= stHit;
            clearReg <= 1'b0;
          end else if (!SC_STATEMACHINEMOVE_goal_InLow) begin
            state  <= stWin;
            winReg <= 1'b1;
          end else begin
            state <= stHold;
            timer <= '0;
          end
        end
        stHold: begin
          if (!SC_STATEMACHINEMOVE_collision_InLow) begin
            state    <= stHit;
            clearReg <= 1'b0;
          end else if (!SC_STATEMACHINEMOVE_goal_InLow) begin
            state  <= stWin;
            winReg <= 1'b1;
          end else if (allReleased) begin
            state      <= stCheck;
            repeatFlag <= 1'b0;
          end else if (timer == timerLast) begin
            if (latchedValid) begin
              state      <= stMove;
              repeatFlag <= 1'b1;
              cmdReg     <= cmdFor(dirReg);
            end else begin
              timer <= '0;
            end
          end else begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end
        stHit: begin
          lives <= (lives == '0) ? '0 : lives - 1'b1;
          if (lives <= LIVES_WIDTH'(1)) begin
            state       <= stLose;
            gameoverReg <= 1'b1;
          end else begin
            state <= stRelease;
          end
        end
        stWin: begin
          if (!SC_STATEMACHINEMOVE_startButton_InLow) begin
            state    <= stInit;
            clearReg <= 1'b0;
          end else begin
            winReg <= 1'b1;
          end
        end
        stLose: begin
          if (!SC_STATEMACHINEMOVE_startButton_InLow) begin
            state    <= stInit;
            clearReg <= 1'b0;
          end else begin
            gameoverReg <= 1'b1;
          end
        end
        default: state <= stCheck;
      endcase
    end
  end

  assign SC_STATEMACHINEMOVE_clear_OutLow        = clearReg;
  assign SC_STATEMACHINEMOVE_load0_OutLow        = cmdReg[3];
  assign SC_STATEMACHINEMOVE_load1_OutLow        = cmdReg[2];
  assign SC_STATEMACHINEMOVE_shiftselection_Out  = cmdReg[1:0];
  assign SC_STATEMACHINEMOVE_lives_Out           = lives;
  assign SC_STATEMACHINEMOVE_win_Out             = winReg;
  assign SC_STATEMACHINEMOVE_gameover_Out        = gameoverReg;
  assign SC_STATEMACHINEMOVE_state_Out           = state;

endmodule

// File: tb/tb_sc_statemachinemove.sv
// Directed bench for sc_statemachinemove: a cycle-by-cycle vector table, then
// hand-written hold-to-repeat and asynchronous-reset sequences.
module tb_sc_statemachinemove;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic startB = 1'b1, upB = 1'b1, downB = 1'b1, leftB = 1'b1, rightB = 1'b1;
  logic topC = 1'b1, botC = 1'b1, leftC = 1'b1, rightC = 1'b1;
  logic collN = 1'b1, goalN = 1'b1;
  logic clearN, load0N, load1N, win, gameover;
  logic [1:0] shift, lives;
  logic [3:0] stateOut;

  always #5 clk = ~clk;

  sc_statemachinemove #(
    .LIVES_WIDTH(2), .LIVES_INIT(3), .TIMER_WIDTH(25),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .SC_STATEMACHINEMOVE_CLOCK_50(clk),
    .SC_STATEMACHINEMOVE_RESET_InLow(rstN),
    .SC_STATEMACHINEMOVE_startButton_InLow(startB),
    .SC_STATEMACHINEMOVE_upButton_InLow(upB),
    .SC_STATEMACHINEMOVE_downButton_InLow(downB),
    .SC_STATEMACHINEMOVE_leftButton_InLow(leftB),
    .SC_STATEMACHINEMOVE_rightButton_InLow(rightB),
    .SC_STATEMACHINEMOVE_topsidecomparator_InLow(topC),
    .SC_STATEMACHINEMOVE_bottomsidecomparator_InLow(botC),
    .SC_STATEMACHINEMOVE_leftsidecomparator_InLow(leftC),
    .SC_STATEMACHINEMOVE_rightsidecomparator_InLow(rightC),
    .SC_STATEMACHINEMOVE_collision_InLow(collN),
    .SC_STATEMACHINEMOVE_goal_InLow(goalN),
    .SC_STATEMACHINEMOVE_clear_OutLow(clearN),
    .SC_STATEMACHINEMOVE_load0_OutLow(load0N),
    .SC_STATEMACHINEMOVE_load1_OutLow(load1N),
    .SC_STATEMACHINEMOVE_shiftselection_Out(shift),
    .SC_STATEMACHINEMOVE_lives_Out(lives),
    .SC_STATEMACHINEMOVE_win_Out(win),
    .SC_STATEMACHINEMOVE_gameover_Out(gameover),
    .SC_STATEMACHINEMOVE_state_Out(stateOut)
  );

  // Packed view {state, clear, load0, load1, shift, lives, win, gameover}
  logic [13:0] actual;
  assign actual = {stateOut, clearN, load0N, load1N, shift, lives, win, gameover};

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  btn;   // {start, up, down, left, right}
    logic [3:0]  cmp;   // {top, bottom, left, right}
    logic        coll;
    logic        goal;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] ex(input logic [3:0] st, input logic clr, input logic l0,
                                     input logic l1, input logic [1:0] sh, input logic [1:0] lv,
                                     input logic w, input logic g);
    return {st, clr, l0, l1, sh, lv, w, g};
  endfunction

  function automatic vec_t mk(input logic [4:0] btn, input logic [3:0] cmp, input logic coll,
                              input logic goal, input logic [13:0] exp);
    vec_t v;
    v.btn = btn; v.cmp = cmp; v.coll = coll; v.goal = goal; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    checks++;
    if (actual !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, actual, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    {startB, upB, downB, leftB, rightB} = v.btn;
    {topC, botC, leftC, rightC} = v.cmp;
    collN = v.coll;
    goalN = v.goal;
  endtask

  initial begin
    //                 btn       cmp      coll  goal    st  clr  l0   l1   sh     lv     w    g
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(1, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b01111, 4'b1111, 1'b1, 1'b1, ex(2, 1'b0, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b01111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b01111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    // down blocked at bottom edge, left wins
    vecs.push_back(mk(5'b11001, 4'b1011, 1'b1, 1'b1, ex(4, 1'b1, 1'b1, 1'b1, 2'b01, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11001, 4'b1011, 1'b1, 1'b1, ex(5, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    // right blocked for three cycles, then edge comparator releases it
    vecs.push_back(mk(5'b11110, 4'b1110, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11110, 4'b1110, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11110, 4'b1110, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11110, 4'b1111, 1'b1, 1'b1, ex(4, 1'b1, 1'b1, 1'b1, 2'b10, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11110, 4'b1111, 1'b1, 1'b1, ex(5, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    // collision + goal + up together: HIT, no move, no win
    vecs.push_back(mk(5'b10111, 4'b1111, 1'b0, 1'b0, ex(7, 1'b0, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b10111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b10111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b0, ex(8, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b1, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(8, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b1, 1'b0)));
    vecs.push_back(mk(5'b01111, 4'b1111, 1'b1, 1'b1, ex(2, 1'b0, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    // three collisions down to LOSE
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b0, 1'b1, ex(7, 1'b0, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b0, 1'b1, ex(7, 1'b0, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd1, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd1, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b0, 1'b1, ex(7, 1'b0, 1'b1, 1'b1, 2'b11, 2'd1, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(9, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b1)));
    vecs.push_back(mk(5'b10111, 4'b1111, 1'b1, 1'b1, ex(9, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b1)));
    vecs.push_back(mk(5'b11101, 4'b1111, 1'b1, 1'b1, ex(9, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b1)));
    vecs.push_back(mk(5'b01111, 4'b1111, 1'b1, 1'b1, ex(2, 1'b0, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b01111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    // up move, collision during HOLD
    vecs.push_back(mk(5'b10111, 4'b1111, 1'b1, 1'b1, ex(4, 1'b1, 1'b0, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b10111, 4'b1111, 1'b1, 1'b1, ex(5, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b10111, 4'b1111, 1'b0, 1'b1, ex(7, 1'b0, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    // down move, goal during MOVE
    vecs.push_back(mk(5'b11011, 4'b1111, 1'b1, 1'b1, ex(4, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11011, 4'b1111, 1'b1, 1'b0, ex(8, 1'b1, 1'b1, 1'b1, 2'b11, 2'd2, 1'b1, 1'b0)));
    vecs.push_back(mk(5'b01111, 4'b1111, 1'b1, 1'b1, ex(2, 1'b0, 1'b1, 1'b1, 2'b11, 2'd2, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(6, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));
    vecs.push_back(mk(5'b11111, 4'b1111, 1'b1, 1'b1, ex(3, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0)));

    rstN = 1'b0;
    @(negedge clk);
    check("reset_values", ex(0, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0));
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Continuous up hold from CHECK: MOVE at 0, 9, then every 5 cycles.
    upB = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic isMove;
      isMove = (i == 0) || (i == 9) || (i == 14) || (i == 19) || (i == 24) || (i == 29);
      @(negedge clk);
      check($sformatf("repeat_c%0d", i),
            ex(isMove ? 4'd4 : 4'd5, 1'b1, ~isMove, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0));
    end

    // Asynchronous reset in the middle of HOLD with up still held.
    @(negedge clk);
    check("hold_before_reset", ex(5, 1'b1, 1'b1, 1'b1, 2'b11, 2'd3, 1'b0, 1'b0));
    #2 rstN = 1'b0;
    #1 check("async_reset", ex(0, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0));
    @(negedge clk);
    check("reset_held", ex(0, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0));
    rstN = 1'b1;
    @(negedge clk);
    check("reset_to_idle", ex(1, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0));
    upB = 1'b1;
    @(negedge clk);
    check("idle_stays", ex(1, 1'b1, 1'b1, 1'b1, 2'b11, 2'd0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_statemachinemove.md
# sc_statemachinemove

Parametrised game-control FSM for the Frogger board, the next generation of the game state machine. It turns active-low buttons into one-cycle move commands for the frog position registers (clear, up-load, down-load, shift select), with edge blocking on all four board sides. It adds hold-to-repeat with configurable delay and period, a lives counter, collision/goal handling and WIN/LOSE states. It sits between the synchronised button inputs and the frog-position register datapath.

## Interface

Parameters:
- LIVES_WIDTH, 2, width of lives counter
- LIVES_INIT, 3, lives loaded at game start (1..2^LIVES_WIDTH-1)
- TIMER_WIDTH, 25, width of repeat timer
- REPEAT_DELAY, 25000000, cycles held before first auto-repeat (≥2, < 2^TIMER_WIDTH)
- REPEAT_PERIOD, 5000000, cycles between later auto-repeats (≥2, < 2^TIMER_WIDTH)

Ports:
- SC_STATEMACHINEMOVE_CLOCK_50  in  1  system clock
- SC_STATEMACHINEMOVE_RESET_InLow  in  1  asynchronous, active-low reset
- SC_STATEMACHINEMOVE_startButton_InLow, _upButton_InLow, _downButton_InLow, _leftButton_InLow, _rightButton_InLow  in  1 each  buttons, already synchronised
- SC_STATEMACHINEMOVE_topsidecomparator_InLow, _bottomsidecomparator_InLow, _leftsidecomparator_InLow, _rightsidecomparator_InLow  in  1 each  low = frog at that edge
- SC_STATEMACHINEMOVE_collision_InLow  in  1  low = frog hit
- SC_STATEMACHINEMOVE_goal_InLow  in  1  low = frog on goal row
- SC_STATEMACHINEMOVE_clear_OutLow  out  1  frog position reset
- SC_STATEMACHINEMOVE_load0_OutLow  out  1  move up
- SC_STATEMACHINEMOVE_load1_OutLow  out  1  move down
- SC_STATEMACHINEMOVE_shiftselection_Out  out  2  01 left, 10 right, 11 hold
- SC_STATEMACHINEMOVE_lives_Out  out  LIVES_WIDTH  remaining lives
- SC_STATEMACHINEMOVE_win_Out  out  1  high in WIN
- SC_STATEMACHINEMOVE_gameover_Out  out  1  high in LOSE
- SC_STATEMACHINEMOVE_state_Out  out  4  current state code (debug)

## Operation

- States and codes: RESET 0, IDLE 1, INIT 2, CHECK 3, MOVE 4, HOLD 5, RELEASE 6, HIT 7, WIN 8, LOSE 9. Codes 10–15 go to CHECK with idle outputs.
- RESET → IDLE unconditionally.
- IDLE: start low → INIT.
- INIT: clear_OutLow=0 for one cycle. Lives load LIVES_INIT and win/gameover clear on exit edge. INIT → RELEASE.
- RELEASE: stays until all five buttons are high, then → CHECK.
- CHECK: evaluated in priority order collision > goal > start > up > down > left > right.
  - collision low → HIT.
  - goal low → WIN.
  - start low → INIT (restart).
  - A direction counts only if its button is low and its side comparator is high. A blocked direction is treated as not pressed, and priority falls through to the next direction.
  - Valid direction → MOVE, latching the direction into a 2-bit register.
- MOVE: one cycle asserting exactly one command for the latched direction: up → load0=0, down → load1=0, left → shift=01, right → shift=10. MOVE → HOLD, unless collision or goal is low, which gives → HIT / WIN.
- HOLD: timer starts at 0 on entry and increments each cycle.
  - collision low → HIT; goal low → WIN.
  - All buttons high → CHECK, clearing the repeat flag.
  - Timer == limit−1 (limit = REPEAT_DELAY if repeat flag is 0, else REPEAT_PERIOD):
    - Latched button still low and unblocked → MOVE, setting the repeat flag.
    - Otherwise, restart the timer and stay in HOLD.
  - Other buttons pressed in HOLD are ignored.
- HIT: clear_OutLow=0 for one cycle, and lives decrement, saturating at 0. If lives were ≤1 → LOSE, otherwise → RELEASE.
- WIN / LOSE: hold the flag high. start low → INIT.
- Idle outputs in every state not listed above: clear=1, load0=1, load1=1, shift=11.
- collision and goal are ignored in RESET, IDLE, INIT, RELEASE, HIT, WIN and LOSE.

## Timing

- Reset values while RESET_InLow=0, asynchronously: state RESET, clear=1, load0=1, load1=1, shift=11, lives=0, win=0, gameover=0, timer=0, repeat flag=0.
- Reset mid-operation aborts any command immediately; an in-progress MOVE pulse is truncated.
- Outputs are Moore, decoded from the state register. Button low sampled at edge k in CHECK gives the command during cycle k+1 and exactly one cycle wide.
- Continuous hold: MOVE cycles at relative cycles 0, REPEAT_DELAY+1, then every REPEAT_PERIOD+1 after that.
- Release during HOLD gives CHECK on the next edge. The next press gives a fresh MOVE and uses REPEAT_DELAY again.
- Simultaneous collision and goal: collision wins.
- Simultaneous collision and button in CHECK: HIT, no move.
- lives_Out changes on the edge leaving INIT or HIT.

## Test plan

Parameters for all scenarios: REPEAT_DELAY=8, REPEAT_PERIOD=4, LIVES_INIT=3.

- Reset low mid-HOLD with up held → all outputs at reset values immediately. After release, state_Out shows 0 then 1.
- Start pulse, then up held 30 cycles → one clear pulse and lives=3. load0 low at relative cycles 0, 9, 14, 19, 24, 29, each one cycle wide; no other command.
- Down and left pressed together with bottomsidecomparator=0 → shift=01 once. load1 never asserts.
- Three collision pulses, each separated by a button release → lives 2, 1, 0. Three clear pulses, then gameover=1 and state 9. Further buttons produce no commands until start.
- Goal and collision low together in CHECK → HIT: lives decrement, win stays 0. Goal alone later → win=1. Start → INIT with win=0.
- Right held with rightsidecomparator=0 → no command. Comparator rises after 3 cycles → shift=10 within 2 cycles.
